// File: rtl/window_gen.sv
// rtl/window_gen.sv - raster-scan 3x3 sliding window generator with two line buffers
// Window registers and position counters reset; line buffer contents are left uninitialised.
module window_gen #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] a00,
  output logic [WIDTH-1:0] a01,
  output logic [WIDTH-1:0] a02,
  output logic [WIDTH-1:0] a10,
  output logic [WIDTH-1:0] a11,
  output logic [WIDTH-1:0] a12,
  output logic [WIDTH-1:0] a20,
  output logic [WIDTH-1:0] a21,
  output logic [WIDTH-1:0] a22,
  output logic             win_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [WIDTH-1:0] win_q [9];
  logic [WIDTH-1:0] win_d [9];
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [WIDTH-1:0] lb1_q [IMG_W];
  logic [WIDTH-1:0] lb2_q [IMG_W];
  logic [WIDTH-1:0] lb1_rd, lb2_rd;
  logic             last_col, last_row;

  always_comb begin
    // sync_clr together with a pixel makes that pixel position (0,0)
    cur_col      = sync_clr ? '0 : col_q;
    cur_row      = sync_clr ? '0 : row_q;
    lb1_rd       = lb1_q[cur_col];
    lb2_rd       = lb2_q[cur_col];
    last_col     = (cur_col == CW'(IMG_W - 1));
    last_row     = (cur_row == RW'(IMG_H - 1));
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      win_d[0]     = win_q[1];
      win_d[1]     = win_q[2];
      win_d[2]     = lb2_rd;
      win_d[3]     = win_q[4];
      win_d[4]     = win_q[5];
      win_d[5]     = lb1_rd;
      win_d[6]     = win_q[7];
      win_d[7]     = win_q[8];
      win_d[8]     = pix_in;
      win_valid_d  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_done_d = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end else if (sync_clr) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  // Line buffer 1 holds row r-1, line buffer 2 holds row r-2
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_q[cur_col] <= pix_in;
      lb2_q[cur_col] <= lb1_rd;
    end
  end

  assign a00        = win_q[0];
  assign a01        = win_q[1];
  assign a02        = win_q[2];
  assign a10        = win_q[3];
  assign a11        = win_q[4];
  assign a12        = win_q[5];
  assign a20        = win_q[6];
  assign a21        = win_q[7];
  assign a22        = win_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - randomized bench for window_gen against an image-array reference model
module tb_window_gen;
  localparam int WD = 9;
  localparam int W  = 4;
  localparam int H  = 4;

  localparam logic [80:0] W_FIRST  = {9'd1, 9'd2, 9'd3, 9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11};
  localparam logic [80:0] W_LAST   = {9'd6, 9'd7, 9'd8, 9'd10, 9'd11, 9'd12, 9'd14, 9'd15, 9'd16};
  localparam logic [80:0] W_FIRST2 = {9'd101, 9'd102, 9'd103, 9'd105, 9'd106, 9'd107, 9'd109, 9'd110, 9'd111};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WD-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          sync_clr = 1'b0;
  logic [WD-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
  logic          win_valid, frame_done;
  logic [80:0]   dut_win;

  int checks = 0;
  int errors = 0;

  window_gen #(.WIDTH(WD), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sync_clr(sync_clr),
    .a00(a00), .a01(a01), .a02(a02), .a10(a10), .a11(a11), .a12(a12),
    .a20(a20), .a21(a21), .a22(a22), .win_valid(win_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  assign dut_win = {a00, a01, a02, a10, a11, a12, a20, a21, a22};

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: the frame as a 2-D image plus the position of the next pixel
  int          img [H][W];
  int          mrow = 0, mcol = 0;
  bit          ev = 0, efd = 0, known = 1;
  logic [80:0] ew = '0;
  logic [80:0] win_log [$];
  bit          fd_log [$];

  always @(posedge clk) begin
    int r, c;
    if (!rst_n) begin
      mrow = 0; mcol = 0; ev = 0; efd = 0; known = 1; ew = '0;
    end else if (pix_valid) begin
      r = sync_clr ? 0 : mrow;
      c = sync_clr ? 0 : mcol;
      img[r][c] = int'(pix_in);
      ev  = (r >= 2) && (c >= 2);
      efd = (r == H - 1) && (c == W - 1);
      known = ev;
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ew = {ew[71:0], 9'(img[r - 2 + i][c - 2 + j])};
      end
      mcol = (c + 1) % W;
      mrow = (c == W - 1) ? (r + 1) % H : r;
    end else begin
      if (sync_clr) begin mrow = 0; mcol = 0; end
      ev = 0; efd = 0;
    end
    #1;
    chk("win_valid", 81'(win_valid), 81'(ev));
    chk("frame_done", 81'(frame_done), 81'(efd));
    if (known) chk("window", dut_win, ew);
    if (win_valid) begin
      win_log.push_back(dut_win);
      fd_log.push_back(frame_done);
    end
  end

  task automatic idle(input int n);
    pix_valid = 1'b0; sync_clr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int v, input bit clr, input int maxgap);
    if (maxgap > 0) idle($urandom_range(maxgap, 1));
    pix_in = WD'(v); pix_valid = 1'b1; sync_clr = clr;
    @(negedge clk);
    pix_valid = 1'b0; sync_clr = 1'b0;
  endtask

  task automatic frame(input int base, input int maxgap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(base + 4 * r + c + 1, 1'b0, maxgap);
  endtask

  task automatic pin_frame(input string tag, input int first_idx, input logic [80:0] first_win);
    chk({tag, " first window"}, (win_log.size() > first_idx) ? win_log[first_idx] : 81'h0, first_win);
    if (win_log.size() >= first_idx + 4) begin
      chk({tag, " last window"}, win_log[first_idx + 3], (first_idx == 0) ? W_LAST : W_LAST + {9{9'd100}});
      chk({tag, " frame_done pattern"},
          81'({fd_log[first_idx], fd_log[first_idx + 1], fd_log[first_idx + 2], fd_log[first_idx + 3]}),
          81'(4'b0001));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset outputs", {dut_win, win_valid, frame_done} , '0);
    rst_n = 1'b1;
    @(negedge clk);

    win_log.delete(); fd_log.delete();
    frame(0, 0); idle(3);
    chk("contiguous window count", 81'(win_log.size()), 81'd4);
    pin_frame("contiguous", 0, W_FIRST);

    win_log.delete(); fd_log.delete();
    frame(0, 3); idle(3);
    chk("gapped window count", 81'(win_log.size()), 81'd4);
    pin_frame("gapped", 0, W_FIRST);

    win_log.delete(); fd_log.delete();
    frame(0, 0); frame(100, 0); idle(3);
    chk("two frame window count", 81'(win_log.size()), 81'd8);
    pin_frame("frame2", 4, W_FIRST2);

    win_log.delete(); fd_log.delete();
    for (int i = 0; i < 7; i++) send(i + 50, 1'b0, 0);
    pix_valid = 1'b0; sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    frame(0, 0); idle(3);
    chk("sync_clr window count", 81'(win_log.size()), 81'd4);
    pin_frame("sync_clr", 0, W_FIRST);

    win_log.delete(); fd_log.delete();
    for (int i = 0; i < 5; i++) send(i + 60, 1'b0, 0);
    send(1, 1'b1, 0);
    for (int i = 1; i < 16; i++) send(i + 1, 1'b0, 0);
    idle(3);
    chk("clr with pixel window count", 81'(win_log.size()), 81'd4);
    pin_frame("clr with pixel", 0, W_FIRST);

    win_log.delete(); fd_log.delete();
    for (int i = 0; i < 9; i++) send(i + 1, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", {dut_win, win_valid, frame_done}, '0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    win_log.delete(); fd_log.delete();
    frame(0, 0); idle(3);
    chk("post reset window count", 81'(win_log.size()), 81'd4);
    pin_frame("post reset", 0, W_FIRST);

    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(16 * 2, 4);
      for (int i = 0; i < n; i++)
        send($urandom_range(511, 0), ($urandom_range(19, 0) == 0), $urandom_range(2, 0));
      if ($urandom_range(1, 0) == 1) begin
        pix_valid = 1'b0; sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter WIDTH, default 9: pixel bit width; equals the WIDTH of the downstream 3x3 convolution unit.
REQ-002 Parameter IMG_W, default 28: pixels per image row; legal range 3..1024.
REQ-003 Parameter IMG_H, default 28: rows per frame; legal range 3..1024.
REQ-004 Clock and reset: the block has one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port pix_in  input  WIDTH  raster-order pixel (row-major, row 0 col 0 first).
REQ-008 Port pix_valid  input  1  pix_in accepted on any rising edge where high; no backpressure.
REQ-009 Port sync_clr  input  1  synchronous frame restart.
REQ-010 Port a00..a22 (9 ports)  output  WIDTH each  registered 3x3 window; aRC is row R, column C, oldest at 00.
REQ-011 Port win_valid  output  1  window outputs hold a complete in-frame 3x3 window.
REQ-012 Port frame_done  output  1  one-cycle pulse marking the last window of a frame.

Function
REQ-013 Internal col counter (0..IMG_W-1) and row counter (0..IMG_H-1) give the position of the next accepted pixel.
REQ-014 Two line buffers of depth IMG_W hold rows r-1 and r-2; each is read and written at index col on every accepted pixel.
REQ-015 On an accepted pixel at (r,c), the window shifts left by one column.
  - new a22 = pix_in; a12 = row r-1 at column c; a02 = row r-2 at column c.
  - a20 <= a21 <= a22; a10 <= a11 <= a12; a00 <= a01 <= a02.
REQ-016 On the same accepted pixel, line buffer 1 at col <= pix_in and line buffer 2 at col <= old line buffer 1 at col.
REQ-017 Latency: window outputs and win_valid update on the same edge that accepts the pixel, so they are visible one cycle after pix_in is presented.
REQ-018 win_valid is 1 for exactly one cycle after each accepted pixel with r>=2 and c>=2, and 0 otherwise.
REQ-019 When pix_valid is low: no counter, buffer or window change; win_valid is 0; a00..a22 hold their values.
REQ-020 Counter advance: col increments; at col=IMG_W-1, col wraps to 0 and row increments.
REQ-021 Frame wrap: at (IMG_H-1, IMG_W-1), row and col both wrap to 0, and frame_done pulses high in the same cycle as that final win_valid.
REQ-022 Windows per frame = (IMG_H-2)*(IMG_W-2), with no window spanning a row boundary or a frame boundary.
REQ-023 sync_clr alone: col and row go to 0; win_valid and frame_done are 0 the next cycle; line buffer contents are not cleared.
REQ-024 sync_clr together with pix_valid: the pixel is accepted as (0,0) and the counters become col=1, row=0.
REQ-025 Window values while win_valid=0 are don't-care, except immediately after reset.
REQ-026 No arithmetic is performed; pixel data passes through bit-exact.

Reset
REQ-027 While rst_n=0, regardless of clk:
  - a00..a22, win_valid, frame_done, col and row are all 0.
  - Line buffer contents are unspecified.
REQ-028 On rst_n release, the first accepted pixel is treated as (0,0); reset mid-frame discards the partial frame.

Verification (IMG_W=4, IMG_H=4, pixel value = 4r+c+1, continuous pix_valid unless stated)
REQ-029 Reset, then stream 16 pixels:
  - first win_valid is 1 the cycle after pixel 11 is accepted.
  - window a00..a22 = 1,2,3,5,6,7,9,10,11.
  - exactly 4 win_valid pulses occur per frame.
REQ-030 Same frame: the last window is a00..a22 = 6,7,8,10,11,12,14,15,16, with frame_done=1 in that cycle only.
REQ-031 Insert pix_valid=0 gaps of 1-3 cycles between pixels:
  - identical window sequence to REQ-029/030.
  - outputs hold and win_valid=0 during the gaps.
REQ-032 Two back-to-back frames, second frame values +100: the second frame's first window is a00=101..a22=111, with no window mixing the two frames.
REQ-033 Assert sync_clr after pixel 7, then stream a full fresh frame: the window sequence matches REQ-029/030 exactly.
REQ-034 Drop rst_n low after pixel 9 for 2 cycles (asynchronously, mid-cycle): all outputs read 0 immediately, then a full fresh frame reproduces REQ-029/030.
